// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte transmitter.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

  // Mode 0: SCLK idles low, data sampled on the rising edge, MSB first.
  localparam logic SpiCpol     = 1'b0;
  localparam logic SpiCpha     = 1'b0;
  localparam logic SpiMsbFirst = 1'b1;

  localparam int unsigned MinClkDiv = 2;

endpackage

// File: rtl/spi_byte_tx_if.sv
// Byte handshake plus SPI pins; master is the transmitter side, slave the upstream/pin side.
interface spi_byte_tx_if;
  logic [7:0] data_in;
  logic       send;
  logic       done;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       cs_n;

  modport master (
    input  data_in,
    input  send,
    output done,
    output busy,
    output sclk,
    output mosi,
    output cs_n
  );

  modport slave (
    output data_in,
    output send,
    input  done,
    input  busy,
    input  sclk,
    input  mosi,
    input  cs_n
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one tick every Div cycles after clr_i is released.
module spi_clk_div #(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntW'(Div - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_byte_tx.sv
// Single-byte SPI mode-0 transmitter, MSB first, with periodic done re-pulse while idle.
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DONE_RETRY = 16
) (
  input  logic          clk_out1,
  input  logic          rst,
  spi_byte_tx_if.master tx_io
);

  localparam int unsigned RetryW = (DONE_RETRY > 1) ? $clog2(DONE_RETRY) : 1;

  spi_state_e        state_q;
  logic [7:0]        shreg_q;
  logic [2:0]        bit_cnt_q;
  logic [RetryW-1:0] retry_q;
  logic              done_q;
  logic              busy_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;
  logic              tick;

  // Divider is held cleared in idle so the first tick lands CLK_DIV cycles after acceptance.
  spi_clk_div #(
    .Div (CLK_DIV)
  ) u_clk_div (
    .clk_i  (clk_out1),
    .rst_i  (rst),
    .clr_i  (state_q == StIdle),
    .tick_o (tick)
  );

  always_ff @(posedge clk_out1 or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      retry_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= SpiCpol;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_io.send) begin
            shreg_q   <= tx_io.data_in;
            mosi_q    <= tx_io.data_in[7];
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StSetup;
          end else if (retry_q == '0) begin
            done_q  <= 1'b1;
            retry_q <= RetryW'(DONE_RETRY - 1);
          end else begin
            retry_q <= retry_q - RetryW'(1);
          end
        end
        StSetup: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            // Data advances only on falling edges so it is stable around each rising edge.
            if (sclk_q) begin
              if (bit_cnt_q == 3'd7) begin
                mosi_q  <= 1'b0;
                state_q <= StHold;
              end else begin
                shreg_q   <= {shreg_q[6:0], 1'b0};
                mosi_q    <= shreg_q[6];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
        end
        StHold: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            retry_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_io.done = done_q;
  assign tx_io.busy = busy_q;
  assign tx_io.sclk = sclk_q;
  assign tx_io.mosi = mosi_q;
  assign tx_io.cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Directed bench for spi_byte_tx: frame table plus reset and idle re-pulse sequences.
module tb_spi_byte_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned DONE_RETRY = 16;

  logic clk;
  logic rst;

  spi_byte_tx_if tx ();

  spi_byte_tx #(
    .CLK_DIV    (CLK_DIV),
    .DONE_RETRY (DONE_RETRY)
  ) dut (
    .clk_out1 (clk),
    .rst      (rst),
    .tx_io    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    int         gap;
    int         inj_at;
    logic [7:0] inj_data;
    logic [7:0] exp_rx;
    int         exp_low;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];
  int   checks;
  int   errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends din, then follows the frame until the next done pulse; leaves time on that pulse.
  task automatic run_frame(input logic [7:0] din, input int inj_at, input logic [7:0] inj_data,
                           output logic [7:0] rx, output int low, output int done_off,
                           output int terr);
    int   rises;
    logic prev_sclk;
    logic prev_mosi;
    rx       = '0;
    low      = 0;
    done_off = -1;
    terr     = 0;
    rises    = 0;
    tx.data_in = din;
    tx.send    = 1'b1;
    step();
    tx.send    = 1'b0;
    tx.data_in = 8'h00;
    prev_sclk  = tx.sclk;
    prev_mosi  = tx.mosi;
    if (tx.mosi !== din[7]) terr++;
    for (int n = 0; n < 200 && done_off < 0; n++) begin
      if (tx.cs_n === 1'b0) low++;
      if (tx.busy !== ~tx.cs_n) terr++;
      if (tx.done === 1'b1) done_off = n;
      if (n > 0) begin
        if (tx.sclk === 1'b1 && prev_sclk === 1'b0) begin
          rx = {rx[6:0], tx.mosi};
          if (n != (2 * rises + 1) * int'(CLK_DIV)) terr++;
          rises++;
        end
        if (tx.mosi !== prev_mosi && !(prev_sclk === 1'b1 && tx.sclk === 1'b0)) terr++;
      end
      prev_sclk  = tx.sclk;
      prev_mosi  = tx.mosi;
      tx.send    = (n == inj_at);
      tx.data_in = (n == inj_at) ? inj_data : 8'h00;
      if (done_off < 0) step();
    end
    tx.send    = 1'b0;
    tx.data_in = 8'h00;
    if (rises != 8) terr++;
  endtask

  task automatic idle_gap(input int gap, output int gerr);
    gerr = 0;
    for (int g = 0; g < gap; g++) begin
      step();
      if (tx.cs_n !== 1'b1 || tx.sclk !== 1'b0 || tx.busy !== 1'b0 || tx.done !== 1'b0) gerr++;
    end
  endtask

  initial begin
    logic [7:0] rx;
    int         low;
    int         done_off;
    int         terr;
    int         gerr;
    int         ierr;

    checks = 0;
    errors = 0;

    //          din    gap inj  injd   exp_rx low done
    vecs[0] = '{8'hA5, 1, -1, 8'h00, 8'hA5, 68, 69};
    vecs[1] = '{8'h00, 1, -1, 8'h00, 8'h00, 68, 69};
    vecs[2] = '{8'hFF, 1, -1, 8'h00, 8'hFF, 68, 69};
    vecs[3] = '{8'h3C, 1, -1, 8'h00, 8'h3C, 68, 69};
    vecs[4] = '{8'h55, 1, 10, 8'h81, 8'h55, 68, 69};
    vecs[5] = '{8'h5A, 0, -1, 8'h00, 8'h5A, 68, 69};  // send while done is high

    rst        = 1'b1;
    tx.send    = 1'b0;
    tx.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs_n", int'(tx.cs_n), 1);
    chk("reset_sclk", int'(tx.sclk), 0);
    chk("reset_mosi", int'(tx.mosi), 0);
    chk("reset_busy", int'(tx.busy), 0);
    chk("reset_done", int'(tx.done), 0);

    rst  = 1'b0;
    ierr = 0;
    for (int n = 1; n <= 33; n++) begin
      step();
      if (tx.done !== ((n == 1 || n == 17 || n == 33) ? 1'b1 : 1'b0)) ierr++;
      if (tx.cs_n !== 1'b1 || tx.sclk !== 1'b0) ierr++;
    end
    chk("idle_done_repulse", ierr, 0);

    for (int i = 0; i < 6; i++) begin
      idle_gap(vecs[i].gap, gerr);
      chk($sformatf("v%0d_gap_idle", i), gerr, 0);
      run_frame(vecs[i].din, vecs[i].inj_at, vecs[i].inj_data, rx, low, done_off, terr);
      chk($sformatf("v%0d_rx", i), int'(rx), int'(vecs[i].exp_rx));
      chk($sformatf("v%0d_cs_low", i), low, vecs[i].exp_low);
      chk($sformatf("v%0d_done_at", i), done_off, vecs[i].exp_done);
      chk($sformatf("v%0d_timing", i), terr, 0);
    end

    // Reset 30 cycles into a 0xF0 frame.
    idle_gap(1, gerr);
    tx.data_in = 8'hF0;
    tx.send    = 1'b1;
    step();
    tx.send    = 1'b0;
    tx.data_in = 8'h00;
    chk("f0_cs_n_low", int'(tx.cs_n), 0);
    repeat (30) step();
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", int'(tx.cs_n), 1);
    chk("midrst_sclk", int'(tx.sclk), 0);
    chk("midrst_mosi", int'(tx.mosi), 0);
    chk("midrst_busy", int'(tx.busy), 0);
    chk("midrst_done", int'(tx.done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("postrst_done", int'(tx.done), 1);

    idle_gap(1, gerr);
    chk("postrst_gap_idle", gerr, 0);
    run_frame(8'hC3, -1, 8'h00, rx, low, done_off, terr);
    chk("postrst_rx", int'(rx), int'(8'hC3));
    chk("postrst_cs_low", low, 68);
    chk("postrst_done_at", done_off, 69);
    chk("postrst_timing", terr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
